// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - fixed-time six-phase T-junction traffic light sequencer
//   clk       in   1  system clock, rising edge (nominally 1 Hz)
//   rst       in   1  asynchronous active-low reset
//   light_M1  out  3  main road direction 1 head, one-hot {red,yellow,green}
//   light_S   out  3  side road head
//   light_MT  out  3  main road turn lane head
//   light_M2  out  3  main road direction 2 head
module traffic_light_ctrl #(
  parameter int PRESCALE = 1,
  parameter int T_MAIN   = 7,
  parameter int T_YEL    = 2,
  parameter int T_TURN   = 5,
  parameter int T_SIDE   = 3
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_S,
  output logic [2:0] light_MT,
  output logic [2:0] light_M2
);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [2:0] S1 = 3'd0;
  localparam logic [2:0] S2 = 3'd1;
  localparam logic [2:0] S3 = 3'd2;
  localparam logic [2:0] S4 = 3'd3;
  localparam logic [2:0] S5 = 3'd4;
  localparam logic [2:0] S6 = 3'd5;

  localparam int T_MAX_A = (T_MAIN > T_YEL) ? T_MAIN : T_YEL;
  localparam int T_MAX_B = (T_TURN > T_SIDE) ? T_TURN : T_SIDE;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;

  // Second counter only ever holds 0..T_MAX-1; keep at least one bit so a
  // degenerate all-ones-second configuration still elaborates.
  localparam int CNT_W = ($clog2(T_MAX) < 1) ? 1 : $clog2(T_MAX);
  localparam int PS_W  = ($clog2(PRESCALE) < 1) ? 1 : $clog2(PRESCALE);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [CNT_W-1:0] sec_cnt;
  logic [CNT_W-1:0] dur_m1;
  logic [PS_W-1:0]  ps_cnt;
  logic             tick;
  logic             state_legal;

  // With PRESCALE=1 the prescaler sits at 0 and tick is permanently high.
  assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  always_comb begin
    dur_m1      = CNT_W'(T_MAIN - 1);
    next_state  = S1;
    state_legal = 1'b1;
    case (state)
      S1: begin dur_m1 = CNT_W'(T_MAIN - 1); next_state = S2; end
      S2: begin dur_m1 = CNT_W'(T_YEL - 1);  next_state = S3; end
      S3: begin dur_m1 = CNT_W'(T_TURN - 1); next_state = S4; end
      S4: begin dur_m1 = CNT_W'(T_YEL - 1);  next_state = S5; end
      S5: begin dur_m1 = CNT_W'(T_SIDE - 1); next_state = S6; end
      S6: begin dur_m1 = CNT_W'(T_YEL - 1);  next_state = S1; end
      default: state_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S1;
      sec_cnt <= '0;
    end else if (!state_legal) begin
      // Corrupted encodings restart the cycle without waiting for a tick.
      state   <= S1;
      sec_cnt <= '0;
    end else if (tick) begin
      if (sec_cnt == dur_m1) begin
        state   <= next_state;
        sec_cnt <= '0;
      end else begin
        sec_cnt <= sec_cnt + 1'b1;
      end
    end
  end

  // Pure Moore decode; illegal encodings show the S1 pattern for the single
  // cycle before recovery so every head stays one-hot.
  always_comb begin
    light_M1 = GREEN;
    light_M2 = GREEN;
    light_MT = RED;
    light_S  = RED;
    case (state)
      S2: begin light_M1 = GREEN;  light_M2 = YELLOW; light_MT = RED;    light_S = RED;    end
      S3: begin light_M1 = GREEN;  light_M2 = RED;    light_MT = GREEN;  light_S = RED;    end
      S4: begin light_M1 = YELLOW; light_M2 = RED;    light_MT = YELLOW; light_S = RED;    end
      S5: begin light_M1 = RED;    light_M2 = RED;    light_MT = RED;    light_S = GREEN;  end
      S6: begin light_M1 = RED;    light_M2 = RED;    light_MT = RED;    light_S = YELLOW; end
      default: begin light_M1 = GREEN; light_M2 = GREEN; light_MT = RED; light_S = RED; end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - directed bench for traffic_light_ctrl across three parameter sets
module tb_traffic_light_ctrl;

  logic clk;
  logic rst;

  logic [2:0] a_m1, a_s, a_mt, a_m2;
  logic [2:0] b_m1, b_s, b_mt, b_m2;
  logic [2:0] c_m1, c_s, c_mt, c_m2;

  int passed;
  int total;

  traffic_light_ctrl dut_a (
    .clk(clk), .rst(rst),
    .light_M1(a_m1), .light_S(a_s), .light_MT(a_mt), .light_M2(a_m2)
  );

  traffic_light_ctrl #(.PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst),
    .light_M1(b_m1), .light_S(b_s), .light_MT(b_mt), .light_M2(b_m2)
  );

  traffic_light_ctrl #(.T_YEL(1), .T_SIDE(1)) dut_c (
    .clk(clk), .rst(rst),
    .light_M1(c_m1), .light_S(c_s), .light_MT(c_mt), .light_M2(c_m2)
  );

  always #5 clk = ~clk;

  // Patterns packed as {M1,M2,MT,S}; R=100 Y=010 G=001.
  localparam logic [11:0] P1 = 12'b001_001_100_100;
  localparam logic [11:0] P2 = 12'b001_010_100_100;
  localparam logic [11:0] P3 = 12'b001_100_001_100;
  localparam logic [11:0] P4 = 12'b010_100_010_100;
  localparam logic [11:0] P5 = 12'b100_100_100_001;
  localparam logic [11:0] P6 = 12'b100_100_100_010;

  // Expected lights in cycle t after release, from phase lengths in seconds.
  function automatic logic [11:0] exp_lights(input int t, input int ps, input int ty, input int ts);
    int sec;
    int per;
    int s;
    sec = t / ps;
    per = 7 + ty + 5 + ty + ts + ty;
    s   = sec % per;
    if (s < 7)                          return P1;
    else if (s < 7 + ty)                return P2;
    else if (s < 12 + ty)               return P3;
    else if (s < 12 + 2 * ty)           return P4;
    else if (s < 12 + 2 * ty + ts)      return P5;
    else                                return P6;
  endfunction

  function automatic logic safe(input logic [11:0] l);
    logic [2:0] m1, m2, mt, s;
    logic ok;
    {m1, m2, mt, s} = l;
    ok = $onehot(m1) && $onehot(m2) && $onehot(mt) && $onehot(s);
    if (s == 3'b001 && !(m1 == 3'b100 && m2 == 3'b100 && mt == 3'b100)) ok = 1'b0;
    if (mt == 3'b001 && m2 != 3'b100) ok = 1'b0;
    return ok;
  endfunction

  task automatic check(input string tag, input int t, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle=%0d observed=%b required=%b", tag, t, obs, exp);
    total++;
    assert (safe(obs) === 1'b1) passed++;
    else $error("FAIL %s_safety cycle=%0d observed=%b required=onehot_no_conflict", tag, t, obs);
  endtask

  task automatic check_all(input string tag, input int t, input logic held);
    if (held) begin
      check({tag, "_a"}, t, {a_m1, a_m2, a_mt, a_s}, P1);
      check({tag, "_b"}, t, {b_m1, b_m2, b_mt, b_s}, P1);
      check({tag, "_c"}, t, {c_m1, c_m2, c_mt, c_s}, P1);
    end else begin
      check({tag, "_a"}, t, {a_m1, a_m2, a_mt, a_s}, exp_lights(t, 1, 2, 3));
      check({tag, "_b"}, t, {b_m1, b_m2, b_mt, b_s}, exp_lights(t, 4, 2, 3));
      check({tag, "_c"}, t, {c_m1, c_m2, c_mt, c_s}, exp_lights(t, 1, 1, 1));
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    clk    = 1'b0;
    rst    = 1'b0;

    // Reset held across several edges.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_all("rst_hold", i, 1'b1);
    end

    // Release and run 200 cycles: sequence, period, safety.
    rst = 1'b1;
    for (int t = 0; t < 200; t++) begin
      check_all("run", t, 1'b0);
      @(negedge clk);
    end

    // Restart, advance to cycle 11 (default DUT mid-S3), pulse reset.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 12; t++) begin
      check_all("pre_pulse", t, 1'b0);
      if (t < 11) @(negedge clk);
    end
    #2 rst = 1'b0;
    #1 check_all("pulse_async", 11, 1'b1);
    @(negedge clk);
    check_all("pulse_held", 12, 1'b1);
    rst = 1'b1;
    for (int t = 0; t < 30; t++) begin
      check_all("post_pulse", t, 1'b0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
